arbiter_client: RTL and testbench

Requester-side companion to the round-robin arbiter: one instance sits at each arbiter port. It accepts burst commands from a local source, raises its `request` bit, waits for its `grant` bit, streams the burst onto the shared bus while granted, then drops `request` to hand the token on. It handles the arbiter's one-cycle registered grant lag and enforces the idle gap that keeps the arbitration fair.

---
 rtl/arbiter_client.sv | 135 +++++++++++++
 tb/tb_arbiter_client.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_client.sv
// Requester-side client for one round-robin arbiter port: takes burst commands,
// requests the bus, streams beats while granted, then releases. Option macro: ARBITER_CLIENT_BACK2BACK_EN.
module arbiter_client #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int LEN_W     = $clog2(MAX_BURST)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  request_o,
    input  logic                  grant_i,
    output logic                  bus_valid_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_last_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DRAIN
    } state_e;

    state_e                  state_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic                    request_q;
    logic                    bus_valid_q;
    logic                    bus_last_q;
    logic [DATA_WIDTH-1:0]   bus_data_q;

    logic xfer_phase;
    logic beat_fire;
    logic last_beat;
    logic cmd_fire;

    assign xfer_phase = (state_q == ST_WAIT) || (state_q == ST_XFER);
    // Grant seen in DRAIN/IDLE is the arbiter's registered lag and must not pull a beat.
    assign s_ready_o  = xfer_phase && grant_i;
    assign beat_fire  = s_ready_o && s_valid_i;
    assign last_beat  = beat_fire && (cnt_q == len_q);

`ifdef ARBITER_CLIENT_BACK2BACK_EN
    logic chained_q;
    logic chain_ok;

    // Only one command may chain onto a held grant; the next last beat always releases.
    assign chain_ok    = last_beat && !chained_q;
    assign cmd_ready_o = rst_ni && ((state_q == ST_IDLE) || chain_ok);
`else
    assign cmd_ready_o = rst_ni && (state_q == ST_IDLE);
`endif

    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign request_o   = request_q;
    assign bus_valid_o = bus_valid_q;
    assign bus_last_o  = bus_last_q;
    assign bus_data_o  = bus_data_q;
    assign busy_o      = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            request_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
            bus_data_q  <= '0;
`ifdef ARBITER_CLIENT_BACK2BACK_EN
            chained_q   <= 1'b0;
`endif
        end else begin
            bus_valid_q <= beat_fire;
            bus_last_q  <= last_beat;
            if (beat_fire) begin
                bus_data_q <= s_data_i;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        len_q     <= cmd_len_i;
                        cnt_q     <= '0;
                        request_q <= 1'b1;
                        state_q   <= ST_WAIT;
`ifdef ARBITER_CLIENT_BACK2BACK_EN
                        chained_q <= 1'b0;
`endif
                    end
                end

                ST_WAIT, ST_XFER: begin
                    if (beat_fire) begin
                        if (last_beat) begin
`ifdef ARBITER_CLIENT_BACK2BACK_EN
                            if (cmd_fire) begin
                                len_q     <= cmd_len_i;
                                cnt_q     <= '0;
                                chained_q <= 1'b1;
                                state_q   <= ST_XFER;
                            end else begin
                                request_q <= 1'b0;
                                state_q   <= ST_DRAIN;
                            end
`else
                            request_q <= 1'b0;
                            state_q   <= ST_DRAIN;
`endif
                        end else begin
                            cnt_q   <= cnt_q + LEN_W'(1);
                            state_q <= ST_XFER;
                        end
                    end
                end

                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_client.sv
// Self-checking bench for arbiter_client: burst scenario table, hand-written corner
// sequences and random traffic, all checked against a beats-remaining model.
module tb_arbiter_client;

    localparam int DW = 32;
    localparam int MB = 16;
    localparam int LW = 4;
`ifdef ARBITER_CLIENT_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic          clk_i;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [LW-1:0] cmd_len_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i;
    logic          request_o;
    logic          grant_i;
    logic          bus_valid_o;
    logic [DW-1:0] bus_data_o;
    logic          bus_last_o;
    logic          busy_o;

    arbiter_client #(
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_len_i  (cmd_len_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .request_o  (request_o),
        .grant_i    (grant_i),
        .bus_valid_o(bus_valid_o),
        .bus_data_o (bus_data_o),
        .bus_last_o (bus_last_o),
        .busy_o     (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats still owed on the current command, plus the one-cycle release.
    int            rem     = 0;
    bit            drain   = 0;
    bit            chained = 0;
    bit            pv      = 0;
    bit            pl      = 0;
    logic [DW-1:0] pdata   = '0;
    bit            g_bfire = 0;
    logic [DW-1:0] next_data = 32'hA000_0000;

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        bit sr, cr, lastnow, cfire;
        #1;
        if (!rst_ni) begin
            rem = 0; drain = 0; chained = 0; pv = 0; pl = 0; pdata = '0;
        end
        sr      = rst_ni && grant_i && (rem > 0);
        lastnow = sr && s_valid_i && (rem == 1);
        cr      = rst_ni && (((rem == 0) && !drain) || (B2B && lastnow && !chained));
        chk("ctrl", 32'({request_o, cmd_ready_o, s_ready_o, busy_o, bus_valid_o, bus_last_o}),
                    32'({rem > 0, cr, sr, (rem > 0) || drain, pv, pl}));
        chk("data", bus_data_o, pdata);
        cfire   = cmd_valid_i && cr;
        g_bfire = s_valid_i && sr;
        @(posedge clk_i);
        if (rst_ni) begin
            pv    = g_bfire;
            pl    = g_bfire && (rem == 1);
            drain = 1'b0;
            if (g_bfire) begin
                pdata = s_data_i;
                rem--;
                if (rem == 0) begin
                    if (cfire) begin
                        rem = int'(cmd_len_i) + 1; chained = 1'b1;
                    end else begin
                        drain = 1'b1; chained = 1'b0;
                    end
                end
            end else if (cfire) begin
                rem = int'(cmd_len_i) + 1; chained = 1'b0;
            end
        end else begin
            g_bfire = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; cmd_len_i = '0; grant_i = 1'b0; s_valid_i = 1'b0;
        s_data_i = next_data;
    endtask

    // Issue one command then drive grant/s_valid per cycle k after the accept edge E0.
    task automatic run_burst(input int len, input int gd, input int gap_lo, input int gap_hi,
                             input bit toggle, output int beats, output int last_edge);
        bit done = 0;
        beats = 0; last_edge = -1;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(len); grant_i = 1'b0; s_valid_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        for (int k = 1; k <= 100 && !done; k++) begin
            if (bus_valid_o) beats++;
            if (bus_last_o) begin
                last_edge = k - 1; done = 1;
            end else begin
                grant_i   = (k > gd) && !(k >= gap_lo && k <= gap_hi);
                s_valid_i = toggle ? (k % 2 == 0) : 1'b1;
                s_data_i  = next_data;
                step();
                if (g_bfire) next_data = next_data + 32'd1;
            end
        end
        // grant still high through DRAIN and the following IDLE cycle
        grant_i = 1'b1; s_valid_i = 1'b1; s_data_i = next_data;
        step();
        step();
        idle_inputs();
    endtask

    typedef struct {
        int len;
        int gd;
        int gap_lo;
        int gap_hi;
        bit toggle;
        int exp_beats;
        int exp_edge;
    } vec_t;

    vec_t vecs[7];
    int   beats, last_edge;
    bit   req_hist[48];

    initial begin
        vecs[0] = '{3, 1, 0, 0, 1'b0, 4, 5};    // token local
        vecs[1] = '{1, 5, 0, 0, 1'b0, 2, 7};    // grant delayed 5 cycles
        vecs[2] = '{7, 1, 0, 0, 1'b1, 8, 16};   // source stall 1010...
        vecs[3] = '{3, 1, 4, 6, 1'b0, 4, 8};    // grant drop after beat 2
        vecs[4] = '{0, 1, 0, 0, 1'b0, 1, 2};    // single beat
        vecs[5] = '{15, 1, 0, 0, 1'b0, 16, 17}; // maximum burst
        vecs[6] = '{2, 3, 3, 4, 1'b1, 3, 10};   // late grant plus stalls

        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        #1;
        chk("reset_outs", 32'({request_o, cmd_ready_o, s_ready_o, busy_o, bus_valid_o, bus_last_o}), 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        step();

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].len, vecs[i].gd, vecs[i].gap_lo, vecs[i].gap_hi, vecs[i].toggle,
                      beats, last_edge);
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(vecs[i].exp_beats));
            chk($sformatf("vec%0d_last_edge", i), 32'(last_edge), 32'(vecs[i].exp_edge));
        end

        // Asynchronous reset after beat 2 of an 8-beat burst.
        cmd_valid_i = 1'b1; cmd_len_i = LW'(7); s_data_i = next_data;
        step();
        cmd_valid_i = 1'b0; grant_i = 1'b1; s_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data_i = next_data;
            step();
            if (g_bfire) next_data = next_data + 32'd1;
        end
        chk("pre_reset_busy", 32'({request_o, busy_o, bus_valid_o}), 32'b111);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'({request_o, cmd_ready_o, s_ready_o, busy_o, bus_valid_o, bus_last_o}), 32'd0);
        chk("async_rst_data", bus_data_o, 32'd0);
        step();
        rst_ni = 1'b1;
        idle_inputs();
        step();
        run_burst(0, 1, 0, 0, 1'b0, beats, last_edge);
        chk("post_reset_beats", 32'(beats), 32'd1);
        chk("post_reset_last_edge", 32'(last_edge), 32'd2);

        // Commands queued continuously: measure request high/low run lengths.
        cmd_valid_i = 1'b1; cmd_len_i = LW'(1); grant_i = 1'b1; s_valid_i = 1'b1;
        for (int k = 0; k < 48; k++) begin
            req_hist[k] = request_o;
            s_data_i = next_data;
            step();
            if (g_bfire) next_data = next_data + 32'd1;
        end
        idle_inputs();
        begin
            int run_len = 1, max_hi = 0, min_lo = 1000, runs = 0;
            for (int k = 1; k < 48; k++) begin
                if (req_hist[k] == req_hist[k-1]) begin
                    run_len++;
                end else begin
                    if (runs > 0) begin
                        if (req_hist[k-1]) max_hi = (run_len > max_hi) ? run_len : max_hi;
                        else min_lo = (run_len < min_lo) ? run_len : min_lo;
                    end
                    runs++;
                    run_len = 1;
                end
            end
            chk("queued_max_req_high", 32'(max_hi), B2B ? 32'd4 : 32'd2);
            chk("queued_min_req_low", 32'(min_lo), 32'd2);
        end
        step();
        step();
        step();

        // Random traffic against the model, including one mid-run reset pulse.
        for (int k = 0; k < 800; k++) begin
            rst_ni      = !(k == 400);
            cmd_valid_i = ($urandom_range(0, 2) != 0);
            cmd_len_i   = LW'($urandom_range(0, MB - 1));
            grant_i     = ($urandom_range(0, 3) != 0);
            s_valid_i   = ($urandom_range(0, 3) != 0);
            s_data_i    = next_data;
            step();
            if (g_bfire) next_data = $urandom;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
